// File: rtl/avr_ifetch.sv
// Instruction fetch for avr_cpu: issues reads to a synchronous ROM and queues words in a small FIFO.
// Define IFETCH_WIDE_EN to present 32-bit opcodes (JMP/CALL/LDS/STS) as one unit with instr_ext.
module avr_ifetch #(
    parameter int PADDR_W  = 9,
    parameter int DEPTH    = 2,
    parameter int RESET_PC = 0
) (
    input  logic               CLK,
    input  logic               RST,
    output logic [PADDR_W-1:0] pm_addr,
    output logic               pm_rd,
    input  logic [15:0]        pm_data,
    output logic [15:0]        instr,
`ifdef IFETCH_WIDE_EN
    output logic [15:0]        instr_ext,
`endif
    output logic [PADDR_W-1:0] instr_pc,
    output logic               instr_valid,
    input  logic               instr_ack,
    input  logic               redirect,
    input  logic [PADDR_W-1:0] redirect_pc
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PADDR_W-1:0] W_RST_PC = PADDR_W'(RESET_PC);

    logic [15:0]        r_word [DEPTH];
    logic [PADDR_W-1:0] r_wpc  [DEPTH];
    logic [PTR_W-1:0]   r_head, r_tail;
    logic [CNT_W-1:0]   r_count;
    logic [PADDR_W-1:0] r_fetch_pc;
    logic               r_infl;
    logic [PADDR_W-1:0] r_infl_pc;

    logic [CNT_W:0]     w_occ;
    logic               w_push;
    logic               w_pop;
    logic [1:0]         w_pop_n;
    logic               w_valid;
    logic [PTR_W-1:0]   w_head1;

    function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // In-flight read counts against free space so a returning word always has a slot.
    assign w_occ   = {1'b0, r_count} + {{CNT_W{1'b0}}, r_infl};
    assign pm_rd   = !RST && !redirect && (w_occ < (CNT_W+1)'(DEPTH));
    assign pm_addr = r_fetch_pc;
    assign w_push  = r_infl && !redirect;
    assign w_head1 = f_inc(r_head);

`ifdef IFETCH_WIDE_EN
    function automatic logic f_is32(input logic [15:0] w);
        return ((w & 16'hFE0C) == 16'h940C) || ((w & 16'hFC0F) == 16'h9000);
    endfunction

    logic w_is32;
    assign w_is32    = f_is32(r_word[r_head]);
    assign w_valid   = (r_count != '0) && (!w_is32 || (r_count >= CNT_W'(2)));
    assign instr_ext = (w_valid && w_is32) ? r_word[w_head1] : 16'h0000;
    assign w_pop_n   = w_pop ? (w_is32 ? 2'd2 : 2'd1) : 2'd0;
`else
    assign w_valid   = (r_count != '0);
    assign w_pop_n   = w_pop ? 2'd1 : 2'd0;
`endif

    assign w_pop       = w_valid && instr_ack && !redirect;
    assign instr_valid = w_valid;
    assign instr       = w_valid ? r_word[r_head] : 16'h0000;
    assign instr_pc    = w_valid ? r_wpc[r_head]  : '0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_fetch_pc <= W_RST_PC;
            r_infl     <= 1'b0;
            r_infl_pc  <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            r_infl    <= pm_rd;
            r_infl_pc <= r_fetch_pc;
            if (redirect) begin
                // The return landing this cycle belongs to the old stream and is dropped.
                r_fetch_pc <= redirect_pc;
                r_head     <= '0;
                r_tail     <= '0;
                r_count    <= '0;
            end else begin
                if (pm_rd)
                    r_fetch_pc <= r_fetch_pc + 1'b1;
                if (w_push)
                    r_tail <= f_inc(r_tail);
                if (w_pop_n == 2'd2)
                    r_head <= f_inc(w_head1);
                else if (w_pop_n == 2'd1)
                    r_head <= w_head1;
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop_n);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_word[r_tail] <= pm_data;
            r_wpc[r_tail]  <= r_infl_pc;
        end
    end

endmodule

// File: tb/tb_avr_ifetch.sv
// Directed bench for avr_ifetch: a DEPTH=4 unit for streaming/redirect/reset, a DEPTH=2 unit for backpressure.
module tb_avr_ifetch;
    localparam int AW = 9;

    logic          CLK;
    logic          RST;
    logic [15:0]   rom [512];

    logic [AW-1:0] pm_addr, instr_pc, redirect_pc;
    logic          pm_rd, instr_valid, ack, redirect;
    logic [15:0]   pm_data, instr;
    logic [AW-1:0] pm_addr2, instr_pc2, redirect_pc2;
    logic          pm_rd2, instr_valid2, ack2, redirect2;
    logic [15:0]   pm_data2, instr2;
`ifdef IFETCH_WIDE_EN
    logic [15:0]   instr_ext, instr_ext2;
`endif

    int n_vec = 0;
    int n_err = 0;
    int exp_pc2 = 0;
    int d2_pops = 0;

    avr_ifetch #(.PADDR_W(AW), .DEPTH(4)) u_dut (
        .CLK(CLK), .RST(RST), .pm_addr(pm_addr), .pm_rd(pm_rd), .pm_data(pm_data),
        .instr(instr),
`ifdef IFETCH_WIDE_EN
        .instr_ext(instr_ext),
`endif
        .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ack(ack),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    avr_ifetch #(.PADDR_W(AW), .DEPTH(2)) u_d2 (
        .CLK(CLK), .RST(RST), .pm_addr(pm_addr2), .pm_rd(pm_rd2), .pm_data(pm_data2),
        .instr(instr2),
`ifdef IFETCH_WIDE_EN
        .instr_ext(instr_ext2),
`endif
        .instr_pc(instr_pc2), .instr_valid(instr_valid2), .instr_ack(ack2),
        .redirect(redirect2), .redirect_pc(redirect_pc2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Synchronous ROMs; junk on cycles with no read so mistimed captures show up.
    always @(posedge CLK) begin
        pm_data  <= pm_rd  ? rom[pm_addr]  : 16'hDEAD;
        pm_data2 <= pm_rd2 ? rom[pm_addr2] : 16'hDEAD;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [15:0] w, input logic [AW-1:0] pc);
        chk({tag, "_valid"}, 32'(instr_valid), 32'(v));
        chk({tag, "_instr"}, 32'(instr), 32'(v ? w : 16'h0000));
        chk({tag, "_pc"},    32'(instr_pc), 32'(v ? pc : 9'h000));
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    task automatic next();
        @(posedge CLK);
        #1;
    endtask

    // Every word the DEPTH=2 unit hands over must be the next sequential address.
    always @(negedge CLK) begin
        if (RST) begin
            exp_pc2 = 0;
        end else if (instr_valid2 && ack2) begin
            chk("d2_seq_pc", 32'(instr_pc2), 32'(exp_pc2[AW-1:0]));
            chk("d2_seq_word", 32'(instr2), 32'(rom[exp_pc2[AW-1:0]]));
            exp_pc2++;
            d2_pops++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic        tv [6];
        logic [15:0] tw [6];
        tv = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        tw = '{16'h0000, 16'h0000, 16'hE0A4, 16'h50A1, 16'h50A2, 16'h0000};
        for (int i = 0; i < 512; i++) rom[i] = 16'h1000 + 16'(i);
        rom[0] = 16'hE0A4; rom[1] = 16'h50A1; rom[2] = 16'h50A2; rom[3] = 16'h0000;
        RST = 1'b1; ack = 1'b0; ack2 = 1'b0;
        redirect = 1'b0; redirect_pc = '0; redirect2 = 1'b0; redirect_pc2 = '0;

        repeat (3) @(posedge CLK);
        smp();
        chk("rst_pm_rd", 32'(pm_rd), 0);
        chk("rst_pm_addr", 32'(pm_addr), 0);
        expect_out("rst", 1'b0, 16'h0000, 9'h000);
        chk("rst_d2_valid", 32'(instr_valid2), 0);
        next();
        RST = 1'b0; ack = 1'b1;

        // Cycles 0..5: stream on the main unit, backpressure on the DEPTH=2 unit.
        for (int c = 0; c < 6; c++) begin
            smp();
            expect_out($sformatf("stream_c%0d", c), tv[c], tw[c], AW'(c - 2));
            chk($sformatf("d2_rd_c%0d", c), 32'(pm_rd2), 32'(c < 2));
            if (c < 2) chk($sformatf("d2_addr_c%0d", c), 32'(pm_addr2), 32'(c));
            if (c == 0) begin
                chk("c0_pm_rd", 32'(pm_rd), 1);
                chk("c0_pm_addr", 32'(pm_addr), 0);
            end
            next();
        end
        ack2 = 1'b1;
        redirect = 1'b1; redirect_pc = 9'h040;

        // c6: fifth valid word shown, redirect with ack; ack must not matter.
        smp();
        expect_out("redir_c6", 1'b1, 16'h1004, 9'h004);
        chk("redir_pm_rd", 32'(pm_rd), 0);
        next(); redirect = 1'b0;
        smp();
        expect_out("redir_c7", 1'b0, 16'h0000, 9'h000);
        chk("redir_c7_rd", 32'(pm_rd), 1);
        chk("redir_c7_addr", 32'(pm_addr), 32'h040);
        next();
        smp(); expect_out("redir_c8", 1'b0, 16'h0000, 9'h000);
        next();
        smp(); expect_out("redir_c9", 1'b1, 16'h1040, 9'h040);
        next();
        redirect = 1'b1; redirect_pc = 9'h1FE;
        smp(); expect_out("redir_c10", 1'b1, 16'h1041, 9'h041);
        next(); redirect = 1'b0;
        smp();
        expect_out("wrap_c11", 1'b0, 16'h0000, 9'h000);
        chk("wrap_c11_addr", 32'(pm_addr), 32'h1FE);
        next();
        smp(); expect_out("wrap_c12", 1'b0, 16'h0000, 9'h000);
        next();
        smp(); expect_out("wrap_c13", 1'b1, 16'h11FE, 9'h1FE);
        next();
        smp(); expect_out("wrap_c14", 1'b1, 16'h11FF, 9'h1FF);
        next();
        smp(); expect_out("wrap_c15", 1'b1, 16'hE0A4, 9'h000);
        next();
        smp();
        expect_out("wrap_c16", 1'b1, 16'h50A1, 9'h001);
        chk("inflight_rd", 32'(pm_rd), 1);
        next();

        // Reset pulse with a read in flight.
        RST = 1'b1;
        #1;
        chk("d2_progress", 32'(d2_pops >= 4), 1);
        chk("midrst_pm_rd", 32'(pm_rd), 0);
        chk("midrst_pm_addr", 32'(pm_addr), 0);
        expect_out("midrst", 1'b0, 16'h0000, 9'h000);
        chk("midrst_d2_valid", 32'(instr_valid2), 0);
        chk("midrst_d2_rd", 32'(pm_rd2), 0);
        smp();
        next(); RST = 1'b0;
        smp();
        chk("restart_rd", 32'(pm_rd), 1);
        chk("restart_addr", 32'(pm_addr), 0);
        expect_out("restart_c0", 1'b0, 16'h0000, 9'h000);
        next();
        next();
        smp(); expect_out("restart_c2", 1'b1, 16'hE0A4, 9'h000);
        next();
        smp(); expect_out("restart_c3", 1'b1, 16'h50A1, 9'h001);
        next();

`ifdef IFETCH_WIDE_EN
        RST = 1'b1; ack = 1'b0; ack2 = 1'b0;
        next();
        rom[0] = 16'h940C; rom[1] = 16'h0123; rom[2] = 16'h0F01;
        next(); RST = 1'b0;
        next();
        next();
        smp(); expect_out("wide_c2", 1'b0, 16'h0000, 9'h000);
        next(); ack = 1'b1;
        smp();
        expect_out("wide_c3", 1'b1, 16'h940C, 9'h000);
        chk("wide_c3_ext", 32'(instr_ext), 32'h0123);
        next(); ack = 1'b0;
        smp();
        expect_out("wide_c4", 1'b1, 16'h0F01, 9'h002);
        chk("wide_c4_ext", 32'(instr_ext), 32'h0000);
        next();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
